mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, multiply busy length in clocks.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, divide busy length in clocks.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request from E stage.
REQ-006 SHALL have port op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-007 SHALL have port a  input  32  rs operand (forwarded).
REQ-008 SHALL have port b  input  32  rt operand (forwarded).
REQ-009 SHALL have port cancel  input  1  E-stage flush (exception/interrupt) qualifying start.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse in the cycle HI/LO take a mult/div result.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV with a 4-bit down-counter cnt.
REQ-015 SHALL accept a request only when start=1, cancel=0 and state=IDLE; otherwise request ignored, no state change.
REQ-016 SHALL, on accepted op 0/1, latch a, b and opcode, load cnt=MULT_CYCLES-1, enter MUL.
REQ-017 SHALL, on accepted op 2/3, latch a, b and opcode, load cnt=DIV_CYCLES-1, enter DIV.
REQ-018 SHALL, on accepted op 4 (mthi) or 5 (mtlo), write a into hi or lo at that edge, stay IDLE, busy stays 0.
REQ-019 SHALL ignore accepted op 6/7 (no state, HI/LO change).
REQ-020 SHALL drive busy=1 exactly when state is MUL or DIV: MULT_CYCLES clocks for mult, DIV_CYCLES clocks for div, starting the cycle after the accept edge.
REQ-021 SHALL decrement cnt each clock in MUL/DIV; at the edge where cnt=0, write result to {hi,lo}, return to IDLE.
REQ-022 SHALL drive done=1 in the first IDLE cycle after completion, 0 otherwise.
REQ-023 SHALL compute mult as {hi,lo} = 64-bit signed product of latched a and b; multu as unsigned.
REQ-024 SHALL compute div as lo = signed quotient truncated toward zero, hi = remainder with dividend sign; divu unsigned.
REQ-025 SHALL, for div 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-026 SHALL, for divisor 0, run full DIV_CYCLES busy, leave hi/lo unchanged; done still pulses.
REQ-027 SHALL compute on latched operands only; a/b changes during busy have no effect.
REQ-028 SHALL not abort on cancel while busy; cancel only qualifies start.
REQ-029 SHALL permit a new accept on the edge at which the previous op completes if state is IDLE only after that edge (back-to-back: next start accepted one clock later).
REQ-030 SHALL present hi/lo combinationally from registers (mfhi/mflo read directly; stalling on busy|start is the hazard unit's job).

Reset
REQ-031 SHALL, on reset_n=0 at any time including mid-operation, immediately force state IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, and discard any in-flight op.
REQ-032 SHALL accept a request on the first rising edge after reset_n deasserts.

Verification
REQ-033 SHALL verify mult a=0xFFFFFFFE, b=3 -> busy high 5 clocks, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 clock; multu same -> hi=0x2, lo=0xFFFFFFFA.
REQ-034 SHALL verify div a=-7 (0xFFFFFFF9), b=2 -> busy 10 clocks, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> busy 10 clocks, hi/lo unchanged.
REQ-035 SHALL verify start with cancel=1 (op=mult) -> busy stays 0, hi/lo unchanged; start during busy -> ignored, original result intact.
REQ-036 SHALL verify mthi a=0x12345678 -> hi=0x12345678 next cycle, busy never 1; mtlo analogous.
REQ-037 SHALL verify reset_n pulsed low at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately, no done pulse afterwards.
REQ-038 SHALL verify changing a/b every cycle during a mult -> result reflects operands latched at accept.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multi-cycle multiply/divide unit controller with HI/LO registers.
//
// A request (start & ~cancel while idle) either writes HI/LO directly
// (mthi/mtlo) or latches the operands and runs a fixed-length busy window
// (MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu). The result lands in
// {hi,lo} on the final busy edge and done pulses in the following idle cycle.
// A zero divisor runs the full window but leaves HI/LO untouched.
//
// Ports:
//   clk      in   1   clock, rising edge
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   one-cycle request strobe
//   op       in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 ignored
//   a, b     in  32   rs / rt operands
//   cancel   in   1   flush; suppresses start, never aborts a running op
//   busy     out  1   multiply or divide in progress
//   done     out  1   one-cycle pulse after HI/LO take a mult/div result
//   hi, lo   out 32   HI / LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_a, r_b;
  logic        r_unsigned;
  logic        r_done;
  logic [31:0] r_hi, r_lo;

  logic        w_accept;
  logic        w_finish;

  assign w_accept = start & ~cancel & (r_state == S_IDLE);
  assign w_finish = (r_state != S_IDLE) & (r_cnt == 4'd0);

  // Datapath works only on the latched operands, so a/b may change freely
  // while busy.
  logic [63:0] w_ext_a, w_ext_b, w_prod;
  assign w_ext_a = {{32{~r_unsigned & r_a[31]}}, r_a};
  assign w_ext_b = {{32{~r_unsigned & r_b[31]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case
  // (magnitude 0x80000000 negates back onto itself) and gives truncation
  // toward zero with the remainder taking the dividend's sign.
  logic        w_a_neg, w_b_neg, w_div_zero;
  logic [31:0] w_mag_a, w_mag_b, w_divisor, w_q_mag, w_r_mag, w_quo, w_rem;
  assign w_a_neg    = ~r_unsigned & r_a[31];
  assign w_b_neg    = ~r_unsigned & r_b[31];
  assign w_mag_a    = w_a_neg ? -r_a : r_a;
  assign w_mag_b    = w_b_neg ? -r_b : r_b;
  assign w_div_zero = (r_b == 32'd0);
  assign w_divisor  = w_div_zero ? 32'd1 : w_mag_b;
  assign w_q_mag    = w_mag_a / w_divisor;
  assign w_r_mag    = w_mag_a % w_divisor;
  assign w_quo      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem      = w_a_neg ? -w_r_mag : w_r_mag;

  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            3'd0, 3'd1: begin w_state_nxt = S_MUL; w_cnt_nxt = MUL_LOAD; end
            3'd2, 3'd3: begin w_state_nxt = S_DIV; w_cnt_nxt = DIV_LOAD; end
            default:    ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_unsigned <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_finish;
      if (w_accept) begin
        case (op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            r_a        <= a;
            r_b        <= b;
            r_unsigned <= op[0];
          end
          3'd4:    r_hi <= a;
          3'd5:    r_lo <= a;
          default: ;
        endcase
      end
      if (w_finish) begin
        if (r_state == S_MUL) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else if (!w_div_zero) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
